// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared constants, FSM encoding and leading-zero mask helper for the 7-seg scanner
package seg_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_t;

  // Digits to suppress: enabled "0" patterns above the first enabled non-zero digit; digit 0 always kept.
  function automatic logic [3:0] lz_mask(input logic [3:0][6:0] d, input logic [3:0] en, input int nd);
    logic       leading;
    logic [3:0] mask;
    leading = 1'b1;
    mask    = 4'b0000;
    for (int i = 3; i >= 1; i--) begin
      if (i < nd && en[i]) begin
        if (leading && d[i] == SEG_ZERO) mask[i] = 1'b1;
        else                             leading = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - pattern load bus and board-side seg/anode outputs of the scanner
interface seg_scan_ctrl_if;

  logic       load;
  logic [6:0] d0;
  logic [6:0] d1;
  logic [6:0] d2;
  logic [6:0] d3;
  logic [3:0] digit_en;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_tk;

  modport master (
    output load, d0, d1, d2, d3, digit_en,
    input  seg, an, frame_tk
  );

  modport slave (
    input  load, d0, d1, d2, d3, digit_en,
    output seg, an, frame_tk
  );

endinterface

// File: rtl/seg_scan_ctrl_timer.sv
// rtl/seg_scan_ctrl_timer.sv - slot counter (cnt) and digit index (idx) with slot/frame boundary flags
module seg_slot_timer #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int NUM_DIGITS   = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] idx,
  output logic       blank_last,
  output logic       slot_wrap,
  output logic       frame_end
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] cnt;

  assign slot_wrap  = (cnt == CW'(REFRESH_DIV - 1));
  assign blank_last = (cnt == CW'(BLANK_CYCLES - 1));
  assign frame_end  = slot_wrap && (idx == 2'(NUM_DIGITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_wrap) begin
      cnt <= '0;
      idx <= (idx == 2'(NUM_DIGITS - 1)) ? 2'd0 : idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 7-seg digit scanner with frame-atomic pattern latching and inter-digit blanking
// Optional: define LZ_BLANK_EN for leading-zero blanking.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            reset,
  seg_scan_ctrl_if.slave  bus
);

  logic [1:0]      idx;
  logic            blank_last;
  logic            slot_wrap;
  logic            frame_end;

  logic [3:0][6:0] ld_d;
  logic [3:0][6:0] sh_d, act_d, act_d_nxt;
  logic [3:0]      sh_en, act_en, act_en_nxt;
  logic            pending;
  logic [3:0]      lz_q;
  logic [3:0]      drv_en;

  scan_state_t     state_q, state_d;
  logic [6:0]      seg_d, seg_q;
  logic [3:0]      an_d, an_q;
  logic            ftk_q;

  seg_slot_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .NUM_DIGITS   (NUM_DIGITS)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .idx        (idx),
    .blank_last (blank_last),
    .slot_wrap  (slot_wrap),
    .frame_end  (frame_end)
  );

  assign ld_d = {bus.d3, bus.d2, bus.d1, bus.d0};

  // A load on the boundary cycle is newer than anything pending, so it wins.
  always_comb begin
    act_d_nxt  = act_d;
    act_en_nxt = act_en;
    if (frame_end) begin
      if (bus.load) begin
        act_d_nxt  = ld_d;
        act_en_nxt = bus.digit_en;
      end else if (pending) begin
        act_d_nxt  = sh_d;
        act_en_nxt = sh_en;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_d    <= {4{SEG_BLANK}};
      sh_en   <= 4'b0000;
      act_d   <= {4{SEG_BLANK}};
      act_en  <= 4'b0000;
      pending <= 1'b0;
    end else begin
      act_d  <= act_d_nxt;
      act_en <= act_en_nxt;
      if (bus.load) begin
        sh_d  <= ld_d;
        sh_en <= bus.digit_en;
      end
      if (frame_end)     pending <= 1'b0;
      else if (bus.load) pending <= 1'b1;
    end
  end

`ifdef LZ_BLANK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          lz_q <= 4'b0000;
    else if (frame_end) lz_q <= lz_mask(act_d_nxt, act_en_nxt, NUM_DIGITS);
  end
`else
  assign lz_q = 4'b0000;
`endif

  assign drv_en = act_en & ~lz_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_BLANK;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (blank_last) state_d = ST_ON;
      ST_ON:    if (slot_wrap)  state_d = ST_BLANK;
      default:                  state_d = ST_BLANK;
    endcase
  end

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    if (state_q == ST_ON && drv_en[idx]) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = act_d[idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= SEG_BLANK;
      an_q  <= AN_OFF;
      ftk_q <= 1'b0;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      ftk_q <= frame_end;
    end
  end

  assign bus.seg      = seg_q;
  assign bus.an       = an_q;
  assign bus.frame_tk = ftk_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed bench: frame-atomic loads, boundary load, enables, leading zeros, mid-slot reset
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg_scan_ctrl_if bus_if ();

  seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Patterns visible in each 32-cycle frame after reset release (enables already LZ-adjusted).
  logic [6:0] fr_d  [0:6][0:3];
  logic [3:0] fr_en [0:6];

  // Loads: edge number at which load is sampled, pattern d0..d3, enable.
  int         ld_e  [0:5];
  logic [6:0] ld_d  [0:5][0:3];
  logic [3:0] ld_en [0:5];

  task automatic set_load(input int k, input int e, input logic [6:0] a0, input logic [6:0] a1,
                          input logic [6:0] a2, input logic [6:0] a3, input logic [3:0] en);
    ld_e[k] = e; ld_d[k][0] = a0; ld_d[k][1] = a1; ld_d[k][2] = a2; ld_d[k][3] = a3; ld_en[k] = en;
  endtask

  task automatic set_frame(input int f, input logic [6:0] a0, input logic [6:0] a1,
                           input logic [6:0] a2, input logic [6:0] a3, input logic [3:0] en);
    fr_d[f][0] = a0; fr_d[f][1] = a1; fr_d[f][2] = a2; fr_d[f][3] = a3; fr_en[f] = en;
  endtask

  initial begin
    int         f, s, c;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;

    bus_if.load = 1'b0;
    bus_if.d0 = 7'h00; bus_if.d1 = 7'h00; bus_if.d2 = 7'h00; bus_if.d3 = 7'h00;
    bus_if.digit_en = 4'h0;

    set_load(0,   5, 7'h79, 7'h24, 7'h30, 7'h19, 4'hF);
    set_load(1,  40, 7'h00, 7'h00, 7'h00, 7'h00, 4'hF);
    set_load(2,  50, 7'h79, 7'h24, 7'h02, 7'h19, 4'hF);
    set_load(3,  96, 7'h12, 7'h24, 7'h02, 7'h19, 4'hF);
    set_load(4, 110, 7'h12, 7'h24, 7'h02, 7'h19, 4'b0101);
    set_load(5, 140, 7'h40, 7'h79, 7'h40, 7'h40, 4'hF);

    set_frame(0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'h0);
    set_frame(1, 7'h79, 7'h24, 7'h30, 7'h19, 4'hF);
    set_frame(2, 7'h79, 7'h24, 7'h02, 7'h19, 4'hF);
    set_frame(3, 7'h12, 7'h24, 7'h02, 7'h19, 4'hF);
    set_frame(4, 7'h12, 7'h24, 7'h02, 7'h19, 4'b0101);
`ifdef LZ_BLANK_EN
    set_frame(5, 7'h40, 7'h79, 7'h40, 7'h40, 4'b0011);
    set_frame(6, 7'h40, 7'h40, 7'h40, 7'h40, 4'b0001);
`else
    set_frame(5, 7'h40, 7'h79, 7'h40, 7'h40, 4'hF);
    set_frame(6, 7'h40, 7'h40, 7'h40, 7'h40, 4'hF);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("reset_an",  32'(bus_if.an),       32'hF);
    check("reset_seg", 32'(bus_if.seg),      32'h7F);
    check("reset_ftk", 32'(bus_if.frame_tk), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Edge e samples the state (cnt=(e-1)%8, idx=((e-1)/8)%4); outputs show it right after e.
    for (int e = 1; e <= 224; e++) begin
      bus_if.load = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (ld_e[k] == e || (k == 5 && e == 170)) begin
          bus_if.load = 1'b1;
          bus_if.d0 = (e == 170) ? 7'h40 : ld_d[k][0];
          bus_if.d1 = (e == 170) ? 7'h40 : ld_d[k][1];
          bus_if.d2 = (e == 170) ? 7'h40 : ld_d[k][2];
          bus_if.d3 = (e == 170) ? 7'h40 : ld_d[k][3];
          bus_if.digit_en = (e == 170) ? 4'hF : ld_en[k];
        end
      end
      @(posedge clk);
      #1;
      f = (e - 1) / 32;
      s = ((e - 1) / 8) % 4;
      c = (e - 1) % 8;
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      if (c >= 2 && fr_en[f][s]) begin
        exp_an  = ~(4'b0001 << s);
        exp_seg = fr_d[f][s];
      end
      check($sformatf("an_e%0d", e),  32'(bus_if.an),       32'(exp_an));
      check($sformatf("seg_e%0d", e), 32'(bus_if.seg),      32'(exp_seg));
      check($sformatf("ftk_e%0d", e), 32'(bus_if.frame_tk), (e % 32 == 0) ? 32'h1 : 32'h0);
    end
    bus_if.load = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_an", 32'(bus_if.an), 32'hE);
    #2 reset = 1'b1;
    #1;
    check("midreset_an",  32'(bus_if.an),       32'hF);
    check("midreset_seg", 32'(bus_if.seg),      32'h7F);
    check("midreset_ftk", 32'(bus_if.frame_tk), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int e = 1; e <= 32; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_an_e%0d", e),  32'(bus_if.an),       32'hF);
      check($sformatf("rst_seg_e%0d", e), 32'(bus_if.seg),      32'h7F);
      check($sformatf("rst_ftk_e%0d", e), 32'(bus_if.frame_tk), (e == 32) ? 32'h1 : 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
